// File: rtl/mem_arbiter_2to1_pkg.sv
// Shared types for the 2-to-1 memory arbiter: response codes, per-channel arbiter
// state, and the tie-break helper used by each channel.
package mem_arbiter_2to1_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_e;

  // With both masters requesting the pointer decides; otherwise the lone requester wins.
  function automatic logic pick_master(input logic [1:0] valid, input logic ptr);
    return (&valid) ? ptr : valid[1];
  endfunction

endpackage

// File: rtl/mem_ift.sv
// Memory link with independent read and write request/reply channels.
interface Mem_ift #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  import mem_arbiter_2to1_pkg::*;

  logic                    r_request_valid;
  logic                    r_request_ready;
  logic [ADDR_WIDTH-1:0]   r_request_addr;
  logic                    r_reply_valid;
  logic                    r_reply_ready;
  logic [DATA_WIDTH-1:0]   r_reply_data;
  resp_e                   r_reply_resp;

  logic                    w_request_valid;
  logic                    w_request_ready;
  logic [ADDR_WIDTH-1:0]   w_request_addr;
  logic [DATA_WIDTH-1:0]   w_request_data;
  logic [DATA_WIDTH/8-1:0] w_request_strb;
  logic                    w_reply_valid;
  logic                    w_reply_ready;
  resp_e                   w_reply_resp;

  modport Master (
    output r_request_valid, r_request_addr, r_reply_ready,
    input  r_request_ready, r_reply_valid, r_reply_data, r_reply_resp,
    output w_request_valid, w_request_addr, w_request_data, w_request_strb, w_reply_ready,
    input  w_request_ready, w_reply_valid, w_reply_resp
  );

  modport Slave (
    input  r_request_valid, r_request_addr, r_reply_ready,
    output r_request_ready, r_reply_valid, r_reply_data, r_reply_resp,
    input  w_request_valid, w_request_addr, w_request_data, w_request_strb, w_reply_ready,
    output w_request_ready, w_reply_valid, w_reply_resp
  );
endinterface

// File: rtl/mem_arb_channel.sv
// One arbitrated channel (IDLE -> REQ -> RESP) with grant and priority pointer.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority.
module mem_arb_channel
  import mem_arbiter_2to1_pkg::*;
#(
  parameter int unsigned RESET_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  output logic       dn_req_valid,
  input  logic       dn_req_ready,
  input  logic       dn_rep_valid,
  output logic       dn_rep_ready,
  output logic [1:0] rep_valid,
  input  logic [1:0] rep_ready,
  output arb_state_e state,
  output logic       grant
);

  localparam logic RST_PRI = (RESET_PRIORITY != 0);

  arb_state_e state_nxt;
  logic       grant_nxt;
  logic       ptr;
  logic       ptr_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ARB_IDLE;
      grant <= RST_PRI;
      ptr   <= RST_PRI;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    ptr_nxt      = ptr;
    req_ready    = '0;
    rep_valid    = '0;
    dn_req_valid = 1'b0;
    dn_rep_ready = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (|req_valid) begin
          grant_nxt = pick_master(req_valid, ptr);
          state_nxt = ARB_REQ;
        end
      end
      ARB_REQ: begin
        // Held high for the whole REQ phase so a presented request is never withdrawn.
        dn_req_valid     = 1'b1;
        req_ready[grant] = dn_req_ready;
        if (dn_req_ready) state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        rep_valid[grant] = dn_rep_valid;
        dn_rep_ready     = rep_ready[grant];
        if (dn_rep_valid && rep_ready[grant]) begin
          state_nxt = ARB_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_nxt   = ~grant;
`else
          ptr_nxt   = RST_PRI;
`endif
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Two memory masters onto one downstream link; read and write arbitrated independently.
// Round-robin when MEM_ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise.
module mem_arbiter_2to1
  import mem_arbiter_2to1_pkg::*;
#(
  parameter int unsigned RESET_PRIORITY = 0
) (
  input logic    clk,
  input logic    rstn,
  Mem_ift.Slave  master0,
  Mem_ift.Slave  master1,
  Mem_ift.Master slave0
);

  arb_state_e r_state, w_state;
  logic       r_grant, w_grant;
  logic [1:0] r_req_ready, r_rep_valid, w_req_ready, w_rep_valid;
  logic       r_dn_req_valid, r_dn_rep_ready, w_dn_req_valid, w_dn_rep_ready;
  logic       r_fwd, r_back, w_fwd, w_back;

  mem_arb_channel #(.RESET_PRIORITY(RESET_PRIORITY)) u_rd (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    ({master1.r_request_valid, master0.r_request_valid}),
    .req_ready    (r_req_ready),
    .dn_req_valid (r_dn_req_valid),
    .dn_req_ready (slave0.r_request_ready),
    .dn_rep_valid (slave0.r_reply_valid),
    .dn_rep_ready (r_dn_rep_ready),
    .rep_valid    (r_rep_valid),
    .rep_ready    ({master1.r_reply_ready, master0.r_reply_ready}),
    .state        (r_state),
    .grant        (r_grant)
  );

  mem_arb_channel #(.RESET_PRIORITY(RESET_PRIORITY)) u_wr (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    ({master1.w_request_valid, master0.w_request_valid}),
    .req_ready    (w_req_ready),
    .dn_req_valid (w_dn_req_valid),
    .dn_req_ready (slave0.w_request_ready),
    .dn_rep_valid (slave0.w_reply_valid),
    .dn_rep_ready (w_dn_rep_ready),
    .rep_valid    (w_rep_valid),
    .rep_ready    ({master1.w_reply_ready, master0.w_reply_ready}),
    .state        (w_state),
    .grant        (w_grant)
  );

  assign r_fwd  = (r_state == ARB_REQ);
  assign r_back = (r_state == ARB_RESP);
  assign w_fwd  = (w_state == ARB_REQ);
  assign w_back = (w_state == ARB_RESP);

  assign slave0.r_request_valid = r_dn_req_valid;
  assign slave0.r_reply_ready   = r_dn_rep_ready;
  assign slave0.w_request_valid = w_dn_req_valid;
  assign slave0.w_reply_ready   = w_dn_rep_ready;

  // Request bits follow the grant only while a request is being presented.
  assign slave0.r_request_addr = !r_fwd ? '0 : (r_grant ? master1.r_request_addr : master0.r_request_addr);
  assign slave0.w_request_addr = !w_fwd ? '0 : (w_grant ? master1.w_request_addr : master0.w_request_addr);
  assign slave0.w_request_data = !w_fwd ? '0 : (w_grant ? master1.w_request_data : master0.w_request_data);
  assign slave0.w_request_strb = !w_fwd ? '0 : (w_grant ? master1.w_request_strb : master0.w_request_strb);

  assign master0.r_request_ready = r_req_ready[0];
  assign master1.r_request_ready = r_req_ready[1];
  assign master0.w_request_ready = w_req_ready[0];
  assign master1.w_request_ready = w_req_ready[1];

  assign master0.r_reply_valid = r_rep_valid[0];
  assign master1.r_reply_valid = r_rep_valid[1];
  assign master0.w_reply_valid = w_rep_valid[0];
  assign master1.w_reply_valid = w_rep_valid[1];

  // The non-owning master sees all-zero reply bits (OKAY).
  assign master0.r_reply_data = (r_back && !r_grant) ? slave0.r_reply_data : '0;
  assign master1.r_reply_data = (r_back &&  r_grant) ? slave0.r_reply_data : '0;
  assign master0.r_reply_resp = (r_back && !r_grant) ? slave0.r_reply_resp : OKAY;
  assign master1.r_reply_resp = (r_back &&  r_grant) ? slave0.r_reply_resp : OKAY;
  assign master0.w_reply_resp = (w_back && !w_grant) ? slave0.w_reply_resp : OKAY;
  assign master1.w_reply_resp = (w_back &&  w_grant) ? slave0.w_reply_resp : OKAY;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Bench for mem_arbiter_2to1: queued master drivers, reactive downstream memory, reply scoreboard.
module tb_mem_arbiter_2to1;
  import mem_arbiter_2to1_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam int unsigned RP = 0;
`else
  localparam int unsigned RP = 1;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  Mem_ift #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m0_if ();
  Mem_ift #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m1_if ();
  Mem_ift #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s_if ();

  mem_arbiter_2to1 #(.RESET_PRIORITY(RP)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .master0 (m0_if),
    .master1 (m1_if),
    .slave0  (s_if)
  );

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    resp_e       exp_resp;
  } vec_t;

  // index = master*2 + (write ? 1 : 0)
  vec_t        req_q [4][$];
  vec_t        sb_q  [4][$];
  logic [31:0] dn_order [$];
  logic [31:0] wmem [logic [31:0]];

  int          checks = 0;
  int          errors = 0;
  int          ready_block = 0;
  int          rep_delay = 0;
  bit          r_pend = 0, w_pend = 0, both_seen = 0;
  int          r_cnt = 0, w_cnt = 0;
  logic [31:0] r_data = '0;
  resp_e       r_resp = OKAY, w_resp = OKAY;
  vec_t        tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void mem_rd(input logic [31:0] a, output logic [31:0] d, output resp_e r);
    if (a[31:16] != 16'h0) begin
      d = '0; r = DECERR;
    end else if (wmem.exists(a)) begin
      d = wmem[a]; r = OKAY;
    end else begin
      d = {16'hC0DE, a[15:0]}; r = OKAY;
    end
  endfunction

  function automatic vec_t head(input int i);
    vec_t v;
    v.m = 0; v.wr = 1'b0; v.addr = '0; v.data = '0; v.exp_data = '0; v.exp_resp = OKAY;
    if (req_q[i].size() != 0) v = req_q[i][0];
    return v;
  endfunction

  function automatic logic [11:0] vouts();
    return {s_if.r_request_valid, s_if.w_request_valid, s_if.r_reply_ready, s_if.w_reply_ready,
            m0_if.r_request_ready, m0_if.w_request_ready, m0_if.r_reply_valid, m0_if.w_reply_valid,
            m1_if.r_request_ready, m1_if.w_request_ready, m1_if.r_reply_valid, m1_if.w_reply_valid};
  endfunction

  function automatic bit busy();
    bit b = r_pend | w_pend;
    for (int i = 0; i < 4; i++) b |= (req_q[i].size() != 0) || (sb_q[i].size() != 0);
    return b;
  endfunction

  task automatic drive();
    vec_t h;
    h = head(0);
    m0_if.r_request_valid = (req_q[0].size() != 0);
    m0_if.r_request_addr  = h.addr;
    h = head(1);
    m0_if.w_request_valid = (req_q[1].size() != 0);
    m0_if.w_request_addr  = h.addr;
    m0_if.w_request_data  = h.data;
    m0_if.w_request_strb  = 4'hF;
    h = head(2);
    m1_if.r_request_valid = (req_q[2].size() != 0);
    m1_if.r_request_addr  = h.addr;
    h = head(3);
    m1_if.w_request_valid = (req_q[3].size() != 0);
    m1_if.w_request_addr  = h.addr;
    m1_if.w_request_data  = h.data;
    m1_if.w_request_strb  = 4'hF;
    m0_if.r_reply_ready = 1'b1; m0_if.w_reply_ready = 1'b1;
    m1_if.r_reply_ready = 1'b1; m1_if.w_reply_ready = 1'b1;

    s_if.r_request_ready = (ready_block == 0);
    if (ready_block > 0) ready_block--;
    s_if.w_request_ready = 1'b1;
    s_if.r_reply_valid = r_pend && (r_cnt == 0);
    s_if.r_reply_data  = s_if.r_reply_valid ? r_data : '0;
    s_if.r_reply_resp  = s_if.r_reply_valid ? r_resp : OKAY;
    if (r_pend && r_cnt > 0) r_cnt--;
    s_if.w_reply_valid = w_pend && (w_cnt == 0);
    s_if.w_reply_resp  = s_if.w_reply_valid ? w_resp : OKAY;
    if (w_pend && w_cnt > 0) w_cnt--;
  endtask

  // Decides, with inputs settled, which handshakes complete on the coming posedge.
  task automatic sample();
    logic [3:0]  rq_v, rq_r, rp_v;
    logic [31:0] rp_d [4];
    logic [31:0] rp_s [4];
    vec_t        v;
    rq_v = {m1_if.w_request_valid, m1_if.r_request_valid, m0_if.w_request_valid, m0_if.r_request_valid};
    rq_r = {m1_if.w_request_ready, m1_if.r_request_ready, m0_if.w_request_ready, m0_if.r_request_ready};
    rp_v = {m1_if.w_reply_valid, m1_if.r_reply_valid, m0_if.w_reply_valid, m0_if.r_reply_valid};
    rp_d[0] = m0_if.r_reply_data; rp_d[1] = '0; rp_d[2] = m1_if.r_reply_data; rp_d[3] = '0;
    rp_s[0] = 32'(m0_if.r_reply_resp); rp_s[1] = 32'(m0_if.w_reply_resp);
    rp_s[2] = 32'(m1_if.r_reply_resp); rp_s[3] = 32'(m1_if.w_reply_resp);

    if (s_if.r_request_valid && s_if.w_request_valid) both_seen = 1'b1;
    if (s_if.r_reply_valid && s_if.r_reply_ready) r_pend = 1'b0;
    if (s_if.w_reply_valid && s_if.w_reply_ready) w_pend = 1'b0;
    if (s_if.r_request_valid && s_if.r_request_ready) begin
      r_pend = 1'b1; r_cnt = rep_delay;
      mem_rd(s_if.r_request_addr, r_data, r_resp);
      dn_order.push_back(s_if.r_request_addr);
    end
    if (s_if.w_request_valid && s_if.w_request_ready) begin
      w_pend = 1'b1; w_cnt = rep_delay;
      if (s_if.w_request_addr[31:16] != 16'h0) w_resp = DECERR;
      else begin
        wmem[s_if.w_request_addr] = s_if.w_request_data;
        w_resp = OKAY;
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (rq_v[i] && rq_r[i]) begin
        v = req_q[i].pop_front();
        sb_q[i].push_back(v);
      end
      if (rp_v[i]) begin
        if (sb_q[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_reply idx%0d: got reply valid 1, expected 0", i);
        end else begin
          v = sb_q[i].pop_front();
          if (!v.wr) check($sformatf("rdata_idx%0d_%08h", i, v.addr), rp_d[i], v.exp_data);
          check($sformatf("resp_idx%0d_%08h", i, v.addr), rp_s[i], 32'(v.exp_resp));
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    sample();
  endtask

  task automatic push(input vec_t v);
    req_q[v.m*2 + (v.wr ? 1 : 0)].push_back(v);
  endtask

  task automatic push_rd(input int m, input logic [31:0] a, input logic [31:0] ed, input resp_e er);
    vec_t v;
    v.m = m; v.wr = 1'b0; v.addr = a; v.data = '0; v.exp_data = ed; v.exp_resp = er;
    push(v);
  endtask

  task automatic run_idle(input string name, input int max);
    int n = 0;
    while (busy() && n < max) begin
      cycle();
      n++;
    end
    if (busy()) begin
      checks++; errors++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, max);
    end
    cycle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_order [4];
    logic [31:0] a_hold;

    tbl[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,         32'hC0DE_1000, OKAY};
    tbl[1] = '{1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         OKAY};
    tbl[2] = '{0, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, OKAY};
    tbl[3] = '{1, 1'b0, 32'h2000_0000, 32'h0,         32'h0,         DECERR};
    tbl[4] = '{0, 1'b1, 32'h3000_0000, 32'h1234_5678, 32'h0,         DECERR};
    tbl[5] = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'hC0DE_0010, OKAY};

    drive();
    #1 rstn = 1'b0;
    repeat (3) cycle();
    check("reset_ctrl", 32'(vouts()), 32'h0);
    check("reset_m0_rdata", m0_if.r_reply_data, 32'h0);
    check("reset_m1_rresp", 32'(m1_if.r_reply_resp), 32'(OKAY));
    rstn = 1'b1;
    cycle();
    check("idle_ctrl", 32'(vouts()), 32'h0);

    // Single read: downstream valid one cycle after master valid.
    push_rd(0, 32'h0000_1000, 32'hC0DE_1000, OKAY);
    cycle();
    check("lat_c0_dn_valid", 32'(s_if.r_request_valid), 32'h0);
    cycle();
    check("lat_c1_dn_valid", 32'(s_if.r_request_valid), 32'h1);
    check("lat_c1_dn_addr", s_if.r_request_addr, 32'h0000_1000);
    run_idle("single_read", 20);

    for (int k = 0; k < 6; k++) begin
      push(tbl[k]);
      run_idle($sformatf("vec%0d", k), 30);
    end

    // Collision: both masters keep two reads queued.
    dn_order.delete();
    push_rd(0, 32'h0, 32'hC0DE_0000, OKAY);
    push_rd(0, 32'h4, 32'hC0DE_0004, OKAY);
    push_rd(1, 32'h10, 32'hC0DE_0010, OKAY);
    push_rd(1, 32'h14, 32'hC0DE_0014, OKAY);
    run_idle("collision", 60);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{32'h0, 32'h10, 32'h4, 32'h14};
`else
    exp_order = '{32'h10, 32'h14, 32'h0, 32'h4};
`endif
    check("order_len", dn_order.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < dn_order.size()) check($sformatf("order%0d", k), dn_order[k], exp_order[k]);

    // Concurrent read and write on different masters.
    both_seen = 1'b0;
    push_rd(0, 32'h20, 32'hC0DE_0020, OKAY);
    push('{1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, OKAY});
    run_idle("concurrent", 30);
    check("both_dn_valid", 32'(both_seen), 32'h1);
    push_rd(1, 32'h40, 32'hDEAD_BEEF, OKAY);
    run_idle("readback", 30);

    // Backpressure: five REQ cycles with downstream ready low.
    ready_block = 6;
    push_rd(1, 32'h14, 32'hC0DE_0014, OKAY);
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("bp%0d_valid", k), 32'(s_if.r_request_valid), 32'h1);
      check($sformatf("bp%0d_addr", k), s_if.r_request_addr, 32'h14);
      check($sformatf("bp%0d_m1_ready", k), 32'(m1_if.r_request_ready), 32'h0);
    end
    run_idle("backpressure", 30);

    // Reset while waiting for a reply.
    rep_delay = 20;
    push_rd(0, 32'h8, 32'hC0DE_0008, OKAY);
    repeat (4) cycle();
    check("resp_phase_rready", 32'(s_if.r_reply_ready), 32'h1);
    #1 rstn = 1'b0;
    #1;
    check("async_reset_ctrl", 32'(vouts()), 32'h0);
    for (int i = 0; i < 4; i++) begin
      req_q[i].delete();
      sb_q[i].delete();
    end
    r_pend = 1'b0; w_pend = 1'b0; rep_delay = 0;
    cycle();
    check("reset_held_ctrl", 32'(vouts()), 32'h0);
    rstn = 1'b1;
    cycle();
    push_rd(0, 32'h8, 32'hC0DE_0008, OKAY);
    run_idle("after_reset", 20);
    a_hold = 32'(vouts());
    check("final_idle_ctrl", a_hold, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
